phys_free_list: RTL
===================

Name: phys_free_list

Overview:
- Circular FIFO of free physical register indices for the rename stage.
- Sits directly upstream of the RAT / super_dispatch_t build; supplies the new physical rd for each renamed instruction.
- ROB commit returns the superseded physical register.
- Keeps a speculative read pointer and a committed (retire) read pointer, so a branch mispredict flush restores the free list in one cycle.

Parameters:
- DEPTH, 32, number of entries; must be a power of 2 (matches freelistdepth).
- PREG_W, 6, physical register index width (= $clog2(TABLE_ENTRIES)).
- ARCH_REGS, 32, base index of the initial free registers; reset contents are ARCH_REGS..ARCH_REGS+DEPTH-1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- alloc_req  input  1  rename wants a physical reg this cycle (instruction has_rd, rd != x0)
- alloc_valid  output  1  a free reg is available; combinational
- alloc_preg  output  PREG_W  free reg at the speculative head; combinational
- free_en  input  1  ROB commit of an instruction that allocated a reg
- free_preg  input  PREG_W  previous mapping of the committed rd, returned to the list
- flush  input  1  mispredict recovery; discard speculative allocations
- empty  output  1  no speculative free entries
- count  output  $clog2(DEPTH)+1  speculative free entries, 0..DEPTH

Behaviour:
- Pointers: head (speculative), rhead (retire), tail. Each is $clog2(DEPTH)+1 bits wide, with the MSB as a wrap bit.
- count = tail - head (modular); empty = (count == 0).
- Reset: same edge as rst, mem[i] = ARCH_REGS + i; head = 0; rhead = 0; tail = DEPTH (wrap bit set, index 0).
- Outputs after reset: count = DEPTH, empty = 0, alloc_valid = 1, alloc_preg = ARCH_REGS.
- Reset asserted mid-operation overrides all other inputs.
- Combinational outputs: alloc_valid = !empty; alloc_preg = mem[head[idx]]. alloc_preg is don't-care when empty.
- Pop: occurs when alloc_req && alloc_valid && !flush; head increments at the clock edge.
  - alloc_req while empty is not a pop; rename must stall on !alloc_valid.
- Push: when free_en, mem[tail[idx]] <= free_preg, tail increments and rhead increments.
  - This happens regardless of flush, because commit is non-speculative.
- Flush: head <= rhead_next, where rhead_next includes any same-cycle free_en increment.
  - Same-cycle alloc_req is ignored.
  - count the following cycle = tail_next - rhead_next.
- Simultaneous pop and push (no flush): both take effect and count is unchanged.
  - A push never satisfies a same-cycle pop when empty (no bypass) unless the optional feature is compiled in.
- Full: a push with count == DEPTH is illegal (more frees than allocations). Flagged by a simulation assertion; the hardware behaviour is undefined.
- free_preg == 0 with free_en is illegal (x0 is never renamed); simulation assertion.
- Wrap-around: index = pointer[$clog2(DEPTH)-1:0]. Wrap bits distinguish full from empty. All pointer arithmetic is modulo 2*DEPTH.
- Latency: an allocated reg is visible the same cycle. A freed reg becomes allocatable the cycle after the push.

Optional Feature:
- Macro: FREE_LIST_BYPASS_EN.
- Defined: when empty && free_en && !flush:
  - alloc_valid = 1 and alloc_preg = free_preg combinationally.
  - If alloc_req is also high, head, tail and rhead all increment, and the entry write is harmless.
  - Net count stays 0.
- Not defined: alloc_valid strictly = !empty and the push is visible the next cycle only.

Test Plan:
1. Reset -> count=32, alloc_preg=32. Then 3 cycles of alloc_req -> returns 32, 33, 34; count=29.
2. Drain: 32 consecutive allocs -> last alloc_preg=63; empty=1, alloc_valid=0. A further alloc_req leaves head unchanged and count=0.
3. Wrap: from empty, free_en with preg 5, then 7 -> next cycle count=2; allocs return 5 then 7. Pointers have wrapped: head index 2, wrap bit toggled.
4. Simultaneous: count=10, alloc_req and free_en (preg 40) in the same cycle -> count stays 10; alloc_preg that cycle is the old head; 40 is written at the tail.
5. Flush: reset, allocate 4 (32..35), commit 1 (free preg 3), then flush with free_en (preg 9) in the flush cycle.
   - Next cycle: rhead=2, head=2, tail=34 (index 2), count=32.
   - alloc_preg=34.
6. Bypass (FREE_LIST_BYPASS_EN): empty, free_en with preg 12 and alloc_req in the same cycle -> alloc_valid=1, alloc_preg=12; next cycle count=0. Without the macro: alloc_valid=0, and next cycle count=1 with alloc_preg=12.

Source files
------------

// File: rtl/phys_free_list.sv
// Circular free list of physical register indices with speculative and retire read pointers.
// Optional same-cycle push-to-pop bypass when empty: define FREE_LIST_BYPASS_EN.
module phys_free_list #(
  parameter int DEPTH     = 32,
  parameter int PREG_W    = 6,
  parameter int ARCH_REGS = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_req,
  output logic                       alloc_valid,
  output logic [PREG_W-1:0]          alloc_preg,
  input  logic                       free_en,
  input  logic [PREG_W-1:0]          free_preg,
  input  logic                       flush,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PREG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  rhead_q, rhead_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic              bypass_hit;
  logic              pop;

  assign count = tail_q - head_q;
  assign empty = (count == '0);

`ifdef FREE_LIST_BYPASS_EN
  assign bypass_hit = empty && free_en && !flush;
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    alloc_valid = !empty || bypass_hit;
    alloc_preg  = bypass_hit ? free_preg : mem_q[head_q[IDX_W-1:0]];
    pop         = alloc_req && alloc_valid && !flush;

    rhead_d = free_en ? rhead_q + PTR_W'(1) : rhead_q;
    tail_d  = free_en ? tail_q + PTR_W'(1) : tail_q;
    head_d  = head_q;
    // Flush rewinds to the retire pointer, including this cycle's commit.
    if (flush) begin
      head_d = rhead_d;
    end else if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      rhead_q <= '0;
      tail_q  <= PTR_W'(DEPTH);
    end else begin
      head_q  <= head_d;
      rhead_q <= rhead_d;
      tail_q  <= tail_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_q[gi] <= PREG_W'(ARCH_REGS + gi);
        end else if (free_en && (tail_q[IDX_W-1:0] == IDX_W'(gi))) begin
          mem_q[gi] <= free_preg;
        end
      end
    end
  endgenerate

  // Commits can never outnumber allocations, and x0 is never renamed.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    free_en |-> (count != PTR_W'(DEPTH)));
  a_no_x0_free : assert property (@(posedge clk) disable iff (rst)
    free_en |-> (free_preg != '0));

endmodule
